// File: rtl/nw_pkg.sv
// ============================================================================
// Module   : nw_pkg
// Brief    : Direction pointer encoding and traceback state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nw_pkg;

  localparam logic [1:0] DIR_DIAG = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_LEFT = 2'd2;
  localparam logic [1:0] DIR_BAD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EMIT   = 2'd2,
    ST_FINISH = 2'd3
  } tb_state_t;

endpackage

`default_nettype wire

// File: rtl/nw_dir_ram.sv
// ============================================================================
// Module   : nw_dir_ram
// Brief    : Direction pointer store, one write port, one synchronous read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nw_dir_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [1:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [1:0]    rd_data
);

  logic [1:0] r_mem [DEPTH];
  logic [1:0] r_rd_data;

  // No reset: contents must survive a reset of the traceback engine.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
    if (rd_en) r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/nw_traceback.sv
// ============================================================================
// Module   : nw_traceback
// Brief    : Walks stored NW direction pointers from (len1,len2) to (0,0) and
//            streams edit ops. Option macro: NW_TRACEBACK_CHECK_EN (abort on BAD).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nw_traceback
  import nw_pkg::*;
#(
  parameter int MAX_LENGTH = 16,
  parameter int LWIDTH     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [LWIDTH-1:0] wr_row,
  input  logic [LWIDTH-1:0] wr_col,
  input  logic [1:0]        wr_dir,
  input  logic              start,
  input  logic [LWIDTH-1:0] len1,
  input  logic [LWIDTH-1:0] len2,
  output logic              busy,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [1:0]        op,
  output logic              op_last,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = MAX_LENGTH * MAX_LENGTH;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LWIDTH-1:0] C_MAX = LWIDTH'(MAX_LENGTH);
  localparam logic [LWIDTH-1:0] C_ONE = LWIDTH'(1);

  tb_state_t         r_state, w_state_nxt;
  logic [LWIDTH-1:0] r_i, r_j, w_i_nxt, w_j_nxt;
  logic              r_force;
  logic [1:0]        r_force_dir;
  logic              r_len_err, w_len_err_nxt;
  logic              w_wr_ok, w_abort, w_last;
  logic [1:0]        w_rd_dir, w_dir, w_op;

  function automatic logic [AW-1:0] cell_addr(input logic [LWIDTH-1:0] row,
                                              input logic [LWIDTH-1:0] col);
    return AW'((int'(row) - 1) * MAX_LENGTH + (int'(col) - 1));
  endfunction

  assign w_wr_ok = wr_en && (r_state == ST_IDLE) &&
                   (wr_row != '0) && (wr_row <= C_MAX) &&
                   (wr_col != '0) && (wr_col <= C_MAX);

  nw_dir_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (w_wr_ok),
    .wr_addr (cell_addr(wr_row, wr_col)),
    .wr_data (wr_dir),
    .rd_en   (r_state == ST_FETCH),
    .rd_addr (cell_addr(r_i, r_j)),
    .rd_data (w_rd_dir)
  );

  // Boundary moves override whatever the memory returned for this cell.
  assign w_dir = r_force ? r_force_dir : w_rd_dir;

`ifdef NW_TRACEBACK_CHECK_EN
  assign w_abort = !r_force && (w_rd_dir == DIR_BAD);
  assign w_op    = w_dir;
`else
  assign w_abort = 1'b0;
  assign w_op    = (w_dir == DIR_BAD) ? DIR_DIAG : w_dir;
`endif

  assign w_last = ((w_op == DIR_DIAG) && (r_i == C_ONE) && (r_j == C_ONE)) ||
                  ((w_op == DIR_UP)   && (r_i == C_ONE) && (r_j == '0))    ||
                  ((w_op == DIR_LEFT) && (r_i == '0)    && (r_j == C_ONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_i         <= '0;
      r_j         <= '0;
      r_force     <= 1'b0;
      r_force_dir <= DIR_DIAG;
      r_len_err   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_i       <= w_i_nxt;
      r_j       <= w_j_nxt;
      r_len_err <= w_len_err_nxt;
      if (r_state == ST_FETCH) begin
        r_force     <= (r_i == '0) || (r_j == '0);
        r_force_dir <= (r_i == '0) ? DIR_LEFT : DIR_UP;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_i_nxt       = r_i;
    w_j_nxt       = r_j;
    w_len_err_nxt = 1'b0;
    busy          = 1'b0;
    op_valid      = 1'b0;
    op            = DIR_DIAG;
    op_last       = 1'b0;
    done          = 1'b0;
    err           = r_len_err;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if ((len1 > C_MAX) || (len2 > C_MAX)) begin
            w_len_err_nxt = 1'b1;
          end else if ((len1 == '0) && (len2 == '0)) begin
            w_state_nxt = ST_FINISH;
          end else begin
            w_i_nxt     = len1;
            w_j_nxt     = len2;
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        busy        = 1'b1;
        w_state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        busy = 1'b1;
        if (w_abort) begin
          err         = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          op_valid = 1'b1;
          op       = w_op;
          op_last  = w_last;
          if (op_ready) begin
            if (w_op != DIR_LEFT) w_i_nxt = r_i - C_ONE;
            if (w_op != DIR_UP)   w_j_nxt = r_j - C_ONE;
            w_state_nxt = w_last ? ST_FINISH : ST_FETCH;
          end
        end
      end
      ST_FINISH: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_nw_traceback.sv
// ============================================================================
// Module   : tb_nw_traceback
// Brief    : Directed self-checking bench for nw_traceback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nw_traceback;
  import nw_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [4:0] wr_row, wr_col;
  logic [1:0] wr_dir;
  logic       start;
  logic [4:0] len1, len2;
  logic       busy, op_valid, op_ready, op_last, done, err;
  logic [1:0] op;

  int n_cmp = 0;
  int n_mis = 0;

  logic [1:0] got_op[$];
  logic       got_last[$];
  int first_valid_cyc, done_cyc, done_cnt, err_cyc, err_cnt;
  int busy_seen, busy_after, unstable, end_cyc;

  nw_traceback #(.MAX_LENGTH(16), .LWIDTH(5)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_dir(wr_dir), .start(start), .len1(len1), .len2(len2), .busy(busy),
    .op_valid(op_valid), .op_ready(op_ready), .op(op), .op_last(op_last),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic wr(input logic [4:0] row, input logic [4:0] col, input logic [1:0] dir);
    @(negedge clk);
    wr_en = 1'b1; wr_row = row; wr_col = col; wr_dir = dir;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Cycle 1 is the first negedge after the edge that samples start.
  task automatic trace(input logic [4:0] l1, input logic [4:0] l2,
                       input int stall_at, input int stall_n);
    int stall_left;
    logic [1:0] held;
    got_op.delete(); got_last.delete();
    first_valid_cyc = -1; done_cyc = -1; err_cyc = -1; end_cyc = -1;
    done_cnt = 0; err_cnt = 0; busy_seen = 0; busy_after = -1; unstable = 0;
    stall_left = stall_n; held = 2'd0;
    @(negedge clk);
    start = 1'b1; len1 = l1; len2 = l2; op_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (busy) busy_seen = 1;
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      if (err)  begin err_cnt++;  if (err_cyc < 0)  err_cyc = cyc;  end
      if (op_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (got_op.size() == stall_at && stall_left > 0) begin
          if (stall_left == stall_n) held = op;
          else if (op !== held) unstable++;
          op_ready = 1'b0;
          stall_left--;
        end else begin
          if (stall_n > 0 && got_op.size() == stall_at && op !== held) unstable++;
          op_ready = 1'b1;
          got_op.push_back(op);
          got_last.push_back(op_last);
        end
      end else begin
        op_ready = 1'b1;
      end
      if (end_cyc >= 0 && cyc == end_cyc + 1) begin
        busy_after = busy;
        break;
      end
      if (end_cyc < 0 && (done || err)) end_cyc = cyc;
      @(negedge clk);
    end
    check("trace_terminated", (end_cyc >= 0), 1);
  endtask

  task automatic check_ops(input string tag, input int n, input logic [7:0] eops,
                           input logic [3:0] elast);
    check({tag, "_count"}, got_op.size(), n);
    for (int k = 0; k < n && k < got_op.size(); k++) begin
      check($sformatf("%s_op%0d", tag, k), got_op[k], eops[2*k +: 2]);
      check($sformatf("%s_last%0d", tag, k), got_last[k], elast[k]);
    end
  endtask

  initial begin
    int zero_done;
    rst = 1'b1; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_dir = '0;
    start = 1'b0; len1 = '0; len2 = '0; op_ready = 1'b1;
    #1;
    check("reset_outputs", {busy, op_valid, op, op_last, done, err}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // 1x1; the out-of-range write would alias cell (1,1) if not dropped
    wr(5'd1, 5'd1, DIR_DIAG);
    wr(5'd17, 5'd1, DIR_LEFT);
    wr(5'd0, 5'd1, DIR_UP);
    trace(5'd1, 5'd1, -1, 0);
    check_ops("t1x1", 1, 8'b00, 4'b0001);
    check("t1x1_first_valid", first_valid_cyc, 2);
    check("t1x1_done_cyc", done_cyc, 3);
    check("t1x1_done_cnt", done_cnt, 1);
    check("t1x1_busy_after", busy_after, 0);

    // forced boundary moves
    trace(5'd2, 5'd0, -1, 0);
    check_ops("tbound", 2, {2'd0, 2'd0, DIR_UP, DIR_UP}, 4'b0010);
    check("tbound_done_cyc", done_cyc, 5);
    check("tbound_err_cnt", err_cnt, 0);

    // 2x3 path
    wr(5'd2, 5'd3, DIR_LEFT);
    wr(5'd2, 5'd2, DIR_DIAG);
    wr(5'd1, 5'd1, DIR_DIAG);
    trace(5'd2, 5'd3, -1, 0);
    check_ops("t2x3", 3, {2'd0, DIR_DIAG, DIR_DIAG, DIR_LEFT}, 4'b0100);
    check("t2x3_done_cyc", done_cyc, 7);

    // back-pressure on the second op
    wr(5'd3, 5'd3, DIR_DIAG);
    trace(5'd3, 5'd3, 1, 5);
    check_ops("tbp", 3, {2'd0, DIR_DIAG, DIR_DIAG, DIR_DIAG}, 4'b0100);
    check("tbp_unstable", unstable, 0);
    check("tbp_done_cnt", done_cnt, 1);
    check("tbp_done_cyc", done_cyc, 12);

    // BAD pointer
    wr(5'd2, 5'd2, DIR_BAD);
    trace(5'd2, 5'd2, -1, 0);
`ifdef NW_TRACEBACK_CHECK_EN
    check("tbad_err_cyc", err_cyc, 2);
    check("tbad_first_valid", first_valid_cyc, -1);
    check("tbad_busy_after", busy_after, 0);
    check("tbad_done_cnt", done_cnt, 0);
`else
    check_ops("tbad", 2, {4'd0, DIR_DIAG, DIR_DIAG}, 4'b0010);
    check("tbad_err_cnt", err_cnt, 0);
`endif

    // zero length
    trace(5'd0, 5'd0, -1, 0);
    check("tzero_done_cyc", done_cyc, 1);
    check("tzero_ops", got_op.size(), 0);
    check("tzero_busy_seen", busy_seen, 0);

    // out-of-range length
    trace(5'd17, 5'd3, -1, 0);
    check("trange_err_cyc", err_cyc, 1);
    check("trange_busy_seen", busy_seen, 0);
    check("trange_done_cnt", done_cnt, 0);

    // reset mid-stream, with a write attempted while busy
    wr(5'd2, 5'd2, DIR_DIAG);
    @(negedge clk);
    start = 1'b1; len1 = 5'd2; len2 = 5'd3; op_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10 && !op_valid; k++) @(negedge clk);
    check("trst_valid_before", op_valid, 1);
    wr_en = 1'b1; wr_row = 5'd1; wr_col = 5'd1; wr_dir = DIR_UP;
    @(negedge clk);
    wr_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("trst_outputs_clear", {busy, op_valid, op, op_last, done, err}, 0);
    @(negedge clk);
    rst = 1'b0; op_ready = 1'b1;
    zero_done = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      zero_done += int'(done);
    end
    check("trst_no_done", zero_done, 0);
    trace(5'd2, 5'd3, -1, 0);
    check_ops("trst_replay", 3, {2'd0, DIR_DIAG, DIR_DIAG, DIR_LEFT}, 4'b0100);
    check("trst_replay_done_cnt", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nw_traceback.md
# nw_traceback

Traceback engine for the blocked Needleman-Wunsch aligner. The scoring grid writes one 2-bit direction pointer per cell. This block stores the pointers and, on request, walks them from cell (len1, len2) back to (0,0). It emits the alignment as a stream of edit operations over a valid/ready handshake. It is the read side of the pointer stream that the grid writes.

## Interface
- `MAX_LENGTH`, 16: maximum characters per string; pointer store is MAX_LENGTH×MAX_LENGTH.
- `LWIDTH`, 5: width of row/column indices and lengths; must hold MAX_LENGTH.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `wr_en` input 1: pointer write strobe.
- `wr_row` input LWIDTH: cell row, 1..MAX_LENGTH (indexes s1).
- `wr_col` input LWIDTH: cell column, 1..MAX_LENGTH (indexes s2).
- `wr_dir` input 2: pointer, encoded DIAG=0, UP=1, LEFT=2, BAD=3.
- `start` input 1: begin traceback; `len1`/`len2` are sampled on this cycle.
- `len1` input LWIDTH: s1 length, 0..MAX_LENGTH.
- `len2` input LWIDTH: s2 length, 0..MAX_LENGTH.
- `busy` output 1: traceback in progress.
- `op_valid` output 1: `op` is valid.
- `op_ready` input 1: consumer accepts the op.
- `op` output 2: edit operation, same encoding as `wr_dir`.
- `op_last` output 1: qualifies the final op (the move lands on (0,0)).
- `done` output 1: one-cycle pulse on successful completion.
- `err` output 1: one-cycle pulse on abort.

## Operation
- States are IDLE, FETCH, EMIT and FINISH. Cursor registers are (i, j).
- IDLE
  - `wr_en` writes `wr_dir` at address (wr_row-1)*MAX_LENGTH + (wr_col-1).
  - Writes with row or col equal to 0 or greater than MAX_LENGTH are dropped.
  - `wr_en` is ignored in every state except IDLE.
- IDLE + `start`
  - If len1 > MAX_LENGTH or len2 > MAX_LENGTH: pulse `err` and stay in IDLE.
  - Else if len1 = len2 = 0: go to FINISH.
  - Else load (i, j) = (len1, len2) and go to FETCH.
- `start` is ignored while `busy`.
- FETCH
  - Issues a synchronous read of (i, j), then goes to EMIT.
  - Boundary rule: if i = 0 the op is forced to LEFT; if j = 0 the op is forced to UP. In both cases the memory result is discarded.
- EMIT
  - Drives `op_valid`, with `op` and `op_last` held stable until `op_ready`.
  - `op_last` = (DIAG and i=1, j=1) or (UP and i=1, j=0) or (LEFT and i=0, j=1).
  - On handshake: DIAG decrements i and j; UP decrements i; LEFT decrements j.
  - After the handshake, go to FINISH if `op_last`, else to FETCH.
- FINISH: pulse `done`, return to IDLE.
- Pointer store contents are not reset and survive across tracebacks.

## Timing
- Reset values: `busy`, `op_valid`, `op`, `op_last`, `done` and `err` are all 0; state is IDLE.
- Reset asserted mid-traceback:
  - All outputs clear immediately (asynchronous reset).
  - No `done` pulse.
  - Stored pointers are retained.
- `start` sampled at cycle 0:
  - `busy`=1 from cycle 1.
  - FETCH in cycle 1; first `op_valid` in cycle 2.
- Cadence is one op every 2 cycles when `op_ready` is held high (FETCH+EMIT). Forced boundary moves keep the same cadence.
- `done`:
  - Asserts for one cycle, the cycle after the last handshake.
  - `busy` falls on that same cycle.
  - For a zero-length start, `done` is at cycle 1 with no ops.
- `err` for out-of-range lengths asserts in cycle 1; `busy` never rises.
- A write in the same cycle as `start` is committed. It is visible to the traceback, since the first read occurs in cycle 1.
- The op count for a completed traceback is between max(len1, len2) and len1+len2 inclusive.

## Configuration
- `NW_TRACEBACK_CHECK_EN` defined:
  - A BAD pointer read in FETCH (outside the boundary rule) aborts the traceback.
  - On abort, `err` pulses in the would-be EMIT cycle, no op is emitted, `busy` drops, and there is no `done`.
- `NW_TRACEBACK_CHECK_EN` undefined:
  - BAD is treated as DIAG.
  - `err` pulses only for out-of-range lengths.

## Structure
- Package `nw_pkg` holds the direction localparams (DIR_DIAG, DIR_UP, DIR_LEFT, DIR_BAD) and the state encoding. The grid imports the same direction constants.
- Sub-module `nw_dir_ram`:
  - One write port and one synchronous read port.
  - Depth MAX_LENGTH*MAX_LENGTH, width 2.
  - Address computation stays in the parent.

## Test plan
- 1×1 traceback: write (1,1)=DIAG, start with len1=1, len2=1 → one op DIAG with `op_last`=1 at cycle 2; `done` at cycle 3.
- Forced boundary moves: start with len1=2, len2=0 → ops UP, UP with no memory dependence; `op_last` only on the second op; `done` follows.
- 2×3 path: write (2,3)=LEFT, (2,2)=DIAG, (1,1)=DIAG → ops LEFT, DIAG, DIAG, with `op_last` on the third op.
- Back-pressure: 3×3 all DIAG, with `op_ready` held low for 5 cycles at the second op → `op` stable, exactly 3 ops, `done` once.
- BAD pointer with `NW_TRACEBACK_CHECK_EN`: (2,2)=BAD, start with len1=2, len2=2 → `err` at cycle 2, no `op_valid`, `busy` 0 at cycle 3. The same stimulus without the macro → DIAG emitted.
- Reset mid-stream: `rst` pulsed while `op_valid`=1 → all outputs 0 immediately, no `done`. A re-start afterwards replays identical ops from the retained pointers.
